// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter (ram_port_arb).
package ram_arb_pkg;

  localparam int DEF_AW = 6;
  localparam int DEF_DW = 8;
  // Tag index width covers the largest supported requester count (8).
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_1    = 2'd1,
    PORT_2    = 2'd2
  } port_sel_t;

  // One in-flight read: who asked for it and which RAM port carries it.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    port_sel_t        port;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: returns the first two valid requesters
// found when scanning upward from ptr_i with wrap-around.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   a_idx_o,
  output logic            a_vld_o,
  output logic [IW-1:0]   b_idx_o,
  output logic            b_vld_o
);

  // Scan NREQ slots starting at the pointer; first hit is A, second is B.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    a_idx_o = '0;
    a_vld_o = 1'b0;
    b_idx_o = '0;
    b_vld_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (valid_i[jj]) begin
        if (!a_vld_o) begin
          a_vld_o = 1'b1;
          a_idx_o = jj;
        end else if (!b_vld_o) begin
          b_vld_o = 1'b1;
          b_idx_o = jj;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arb.sv
// Shares the two ports of the 64x8 dual-port RAM between NREQ requesters.
// Winner A drives port 1, winner B drives port 2; same-address pairs with a
// write are serialised. Optional build macro RAM_ARB_CONFLICT_CNT_EN adds a
// saturating 16-bit count of cycles in which winner B was held off.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic              we1,
  output logic [AW-1:0]     addr1,
  output logic [DW-1:0]     data1,
  output logic              we2,
  output logic [AW-1:0]     addr2,
  output logic [DW-1:0]     data2,
  input  logic [DW-1:0]     dout1,
  input  logic [DW-1:0]     dout2
`ifdef RAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] a_idx, b_idx;
  logic          a_vld, b_vld;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_we, b_we;
  logic          hazard, gnt_a, gnt_b;

  logic          we1_q, we2_q;
  logic [AW-1:0] addr1_q, addr2_q;
  logic [DW-1:0] data1_q, data2_q;

  // Index [0] tracks port 1, index [1] tracks port 2.
  rd_tag_t [1:0] tag_p0_d, tag_p0_q, tag_p1_q;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + IW'(1);
  endfunction

  rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .a_idx_o (a_idx),
    .a_vld_o (a_vld),
    .b_idx_o (b_idx),
    .b_vld_o (b_vld)
  );

  assign a_addr  = req_addr[int'(a_idx)*AW +: AW];
  assign b_addr  = req_addr[int'(b_idx)*AW +: AW];
  assign a_wdata = req_wdata[int'(a_idx)*DW +: DW];
  assign b_wdata = req_wdata[int'(b_idx)*DW +: DW];
  assign a_we    = req_we[a_idx];
  assign b_we    = req_we[b_idx];

  // Two reads of one address are harmless; anything involving a write is not.
  assign hazard = a_vld && b_vld && (a_addr == b_addr) && (a_we || b_we);
  assign gnt_a  = a_vld && !rst;
  assign gnt_b  = b_vld && !hazard && !rst;

  // Grant vector and next pointer (one past the last granted requester).
  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    if (gnt_a) begin
      req_ready[a_idx] = 1'b1;
      ptr_d            = next_idx(a_idx);
    end
    if (gnt_b) begin
      req_ready[b_idx] = 1'b1;
      ptr_d            = next_idx(b_idx);
    end
  end

  // Read tags entering the pipeline this cycle; writes carry no tag.
  always_comb begin
    tag_p0_d          = '0;
    tag_p0_d[0].valid = gnt_a && !a_we;
    tag_p0_d[0].idx   = IDX_W'(a_idx);
    tag_p0_d[0].port  = (gnt_a && !a_we) ? PORT_1 : PORT_NONE;
    tag_p0_d[1].valid = gnt_b && !b_we;
    tag_p0_d[1].idx   = IDX_W'(b_idx);
    tag_p0_d[1].port  = (gnt_b && !b_we) ? PORT_2 : PORT_NONE;
  end

  // Round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // RAM port registers; an idle port drops we and keeps address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      we1_q <= gnt_a && a_we;
      we2_q <= gnt_b && b_we;
      if (gnt_a) begin
        addr1_q <= a_addr;
        data1_q <= a_wdata;
      end
      if (gnt_b) begin
        addr2_q <= b_addr;
        data2_q <= b_wdata;
      end
    end
  end

  // Two-stage tag pipeline aligned with the RAM's registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_p0_q <= '0;
      tag_p1_q <= '0;
    end else begin
      tag_p0_q <= tag_p0_d;
      tag_p1_q <= tag_p0_q;
    end
  end

  assign we1   = we1_q;
  assign addr1 = addr1_q;
  assign data1 = data1_q;
  assign we2   = we2_q;
  assign addr2 = addr2_q;
  assign data2 = data2_q;

  // Route returning read data to the requester recorded in the tag.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag_p1_q[p].valid && (tag_p1_q[p].idx == IDX_W'(i))) begin
          rsp_valid[i]          = 1'b1;
          rsp_rdata[i*DW +: DW] = (tag_p1_q[p].port == PORT_2) ? dout2 : dout1;
        end
      end
    end
  end

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of cycles where winner B lost to the hazard rule.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb with a behavioural model of the dual-port RAM.
module tb_ram_port_arb;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rsp_rdata;
  logic               we1, we2;
  logic [AW-1:0]      addr1, addr2;
  logic [DW-1:0]      data1, data2, dout1, dout2;
`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [15:0]        conflict_cnt;
`endif

  ram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .we1       (we1),
    .addr1     (addr1),
    .data1     (data1),
    .we2       (we2),
    .addr2     (addr2),
    .data2     (data2),
    .dout1     (dout1),
    .dout2     (dout2)
`ifdef RAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt (conflict_cnt)
`endif
  );

  // Dual-port RAM: synchronous write, registered read.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
    if (we2) mem[addr2] <= data2;
    dout1 <= mem[addr1];
    dout2 <= mem[addr2];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [7:0]  data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  ref_mem [64];
  int          mptr = 0;
  int          gcount [NREQ];
  logic [15:0] exp_cc = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [NREQ*DW-1:0] pd(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  // One request cycle: drive, predict grants, check ready, log expectations.
  task automatic drive(input logic [3:0] v, input logic [3:0] w,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    int   ai, bi, j;
    bit   av, bv, haz;
    logic [3:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    av = 0; bv = 0; ai = 0; bi = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (mptr + k) % NREQ;
      if (v[j]) begin
        if (!av) begin av = 1; ai = j; end
        else if (!bv) begin bv = 1; bi = j; end
      end
    end
    haz = av && bv && (a[ai*AW +: AW] == a[bi*AW +: AW]) && (w[ai] || w[bi]);
    exp_rdy = '0;
    if (av) exp_rdy[ai] = 1'b1;
    if (bv && !haz) exp_rdy[bi] = 1'b1;
    check_eq("ready", 32'(req_ready), 32'(exp_rdy));
    if (haz && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && v[i]) gcount[i]++;
      if (exp_rdy[i]) begin
        if (w[i]) ref_mem[a[i*AW +: AW]] = d[i*DW +: DW];
        else sb.push_back('{idx: i, data: ref_mem[a[i*AW +: AW]], due: cyc + 2});
      end
    end
    if (bv && !haz) mptr = (bi + 1) % NREQ;
    else if (av)    mptr = (ai + 1) % NREQ;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, '0, '0);
  endtask

  // Response monitor: match each rsp_valid pulse against the scoreboard.
  always @(negedge clk) begin : monitor
    int pos;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          pos = -1;
          foreach (sb[k]) if (pos < 0 && sb[k].idx == i) pos = k;
          if (pos < 0) begin
            check_eq("rsp_unexpected", 32'(rsp_valid[i]), 32'd0);
          end else begin
            check_eq("rsp_data", 32'(rsp_rdata[i*DW +: DW]), 32'(sb[pos].data));
            check_eq("rsp_latency", 32'(cyc), 32'(sb[pos].due));
            sb.delete(pos);
          end
        end
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due < cyc) begin
          check_eq("rsp_missing", 32'(cyc), 32'(sb[k].due));
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    req_valid = 4'hF;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;

    // Reset state, with every requester asserting valid.
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_ram", 32'({we1, we2, addr1, addr2, data1, data2}), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
`ifdef RAM_ARB_CONFLICT_CNT_EN
    check_eq("rst_cc", 32'(conflict_cnt), 32'd0);
`endif
    req_valid = '0;
    rst = 1'b0;

    // Two writes in one cycle, then two reads in one cycle.
    drive(4'b0011, 4'b0011, pa(5, 6, 0, 0), pd(1, 2, 0, 0));
    #1;
    check_eq("ram_ctl", 32'({we1, addr1, data1, we2, addr2, data2}),
             32'({1'b1, 6'd5, 8'd1, 1'b1, 6'd6, 8'd2}));
    drive(4'b1100, 4'b0000, pa(0, 0, 5, 6), '0);
    idle(3);

    // Same-address write/read: B denied, retried next cycle.
    drive(4'b0011, 4'b0001, pa(7, 7, 0, 0), pd(3, 0, 0, 0));
    drive(4'b0010, 4'b0000, pa(0, 7, 0, 0), '0);
`ifdef RAM_ARB_CONFLICT_CNT_EN
    check_eq("cc_hazard", 32'(conflict_cnt), 32'(exp_cc));
`endif
    idle(3);

    // Two reads of one address granted together.
    drive(4'b0011, 4'b0000, pa(5, 5, 0, 0), '0);
    idle(3);

    // Bring the pointer back to 0, then hold all four valid for 8 cycles.
    drive(4'b1000, 4'b0000, pa(0, 0, 0, 5), '0);
    idle(3);
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    for (int c = 0; c < 8; c++)
      drive(4'b1111, 4'b1111, pa(10, 11, 12, 13), pd(c, c + 16, c + 32, c + 48));
    for (int i = 0; i < NREQ; i++) check_eq("fair_cnt", 32'(gcount[i]), 32'd4);
    idle(2);

    // Reset while a read is in flight.
    drive(4'b0100, 4'b0000, pa(0, 0, 6, 0), '0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ram", 32'({we1, we2, addr1, addr2, data1, data2}), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    mptr   = 0;
    exp_cc = 16'd0;
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    idle(4);
    drive(4'b1111, 4'b0000, pa(5, 6, 5, 6), '0);
    idle(3);

`ifdef RAM_ARB_CONFLICT_CNT_EN
    check_eq("cc_after_rst", 32'(conflict_cnt), 32'(exp_cc));
    for (int c = 0; c < 65540; c++)
      drive(4'b0011, 4'b0001, pa(7, 7, 0, 0), pd(3, 0, 0, 0));
    check_eq("cc_sat", 32'(conflict_cnt), 32'h0000FFFF);
    check_eq("cc_model", 32'(conflict_cnt), 32'(exp_cc));
    idle(3);
`endif

    idle(2);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
